reg_wb_queue: RTL and testbench
===============================

Name: reg_wb_queue

Overview:
- Write-port driver for the 32x32 CPU register file: the producer side of its LdR/RD/DataR interface.
- Accepts results from two producers: ALU writeback and memory-load writeback.
- Buffers results in order in a DEPTH-entry FIFO and issues at most one register-file write per CPU-enabled cycle (clk_cpu=1).
- Publishes a pending-write mask so hazard logic can stall readers of registers with queued writes.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >=2.

Ports:
- CLK  input  1  system clock; all state updates on posedge CLK
- RST  input  1  asynchronous, active-high reset
- clk_cpu  input  1  CPU cycle enable; drain only when 1
- alu_valid  input  1  ALU result offered
- alu_ready  output  1  ALU result accepted this cycle if alu_valid
- alu_rd  input  5  ALU destination register
- alu_data  input  32  ALU result
- mem_valid  input  1  load result offered
- mem_ready  output  1  load result accepted this cycle if mem_valid
- mem_rd  input  5  load destination register
- mem_data  input  32  load result
- LdR  output  1  register-file write enable (registered)
- RD  output  5  register-file write address (registered)
- DataR  output  32  register-file write data (registered)
- pend_mask  output  32  bit r=1 while a write to r is queued or presented on LdR
- count  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset, async on RST high: FIFO empty, count=0, LdR=0, RD=0, DataR=0, pend_mask=0. Any in-flight entries are discarded. Outputs must read these values while RST is high.
- Handshake: a transfer occurs on posedge CLK when valid&&ready. Producers hold rd/data stable until accepted.
- Readiness is combinational from count at the start of the cycle. Pops in the same cycle give no credit.
  - alu_ready = (count<DEPTH).
  - mem_ready = (count + (alu_valid&&alu_ready) < DEPTH).
- Ordering: ALU has priority. When both are accepted in one cycle, the ALU entry is enqueued ahead of the mem entry. FIFO order is preserved otherwise.
- x0 filtering: an accepted transfer with rd=0 is consumed (ready behaves normally) but creates no entry. count is unchanged for it.
- Drain, on posedge CLK with clk_cpu=1:
  - If count>0: pop the head into RD/DataR, set LdR=1, count decrements.
  - If count==0: LdR=0; RD/DataR keep their last value.
- With clk_cpu=0: LdR, RD, DataR hold and no pop occurs. Pushes are still accepted.
- Each popped entry is presented with LdR=1 for exactly one clk_cpu-qualified cycle: set on one enabled edge, cleared or replaced on the next enabled edge.
- Simultaneous push and pop: both happen. count updates by +pushes-pop (range 0..DEPTH, never overflows).
- pend_mask: OR of one-hot(rd) over all valid FIFO entries, plus one-hot(RD) when LdR=1. Combinational from registered state. Bit 0 is always 0.
- Latency: a result accepted on edge N into an empty FIFO appears on LdR/RD/DataR at the first clk_cpu=1 edge after N (edge N+1 if clk_cpu stays 1). It is not forwarded on edge N itself.
- Pointers are log2(DEPTH) bits and wrap naturally. Full/empty is decided from count, not pointer equality.

Test Plan:
- Reset: assert RST mid-cycle with 3 entries queued -> LdR=0, count=0, pend_mask=0 immediately. After release, alu_ready=mem_ready=1.
- Single write: clk_cpu=1, alu_valid, rd=5, data=0xDEADBEEF -> next edge: count=1, pend_mask=0x20. Following edge: LdR=1, RD=5, DataR=0xDEADBEEF, count=0. Edge after: LdR=0, pend_mask=0.
- Dual push ordering: clk_cpu=0, ALU rd=3/0x11 and MEM rd=7/0x22 in the same cycle -> count=2, pend_mask=0x88. Then clk_cpu=1 -> writes emitted rd=3 then rd=7 on consecutive edges.
- Backpressure: clk_cpu=0, fill to DEPTH=4 -> alu_ready=0, mem_ready=0. At count=3 with both valid -> ALU accepted, mem_ready=0. Mem entry is accepted only after a drain.
- x0 drop: ALU rd=0 data=0x55 -> accepted, count stays 0, LdR never asserts for RD=0.
- clk_cpu stall: entries queued, clk_cpu toggles 1,0,0,1 -> exactly two pops. LdR/RD/DataR stay constant across the clk_cpu=0 edges.

Source files
------------

// File: rtl/reg_wb_queue.sv
// Register-file write-port driver: merges ALU and load results into an
// in-order FIFO and issues one register write per enabled CPU cycle.
module reg_wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     clk_cpu,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [4:0]               alu_rd,
    input  logic [31:0]              alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [4:0]               mem_rd,
    input  logic [31:0]              mem_data,
    output logic                     LdR,
    output logic [4:0]               RD,
    output logic [31:0]              DataR,
    output logic [31:0]              pend_mask,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    rd_q   [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ldr_q;
    logic [4:0]    rdo_q;
    logic [31:0]   datar_q;

    logic          alu_acc;
    logic          alu_push;
    logic          mem_push;
    logic          pop;
    logic [CW:0]   occ_after_alu;
    logic [AW-1:0] mem_slot;

    // Readiness only looks at occupancy at the start of the cycle.
    assign alu_ready     = count_q < CW'(DEPTH);
    assign alu_acc       = alu_valid && alu_ready;
    assign occ_after_alu = {1'b0, count_q} + {{CW{1'b0}}, alu_acc};
    assign mem_ready     = occ_after_alu < (CW+1)'(DEPTH);

    assign alu_push = alu_acc && (alu_rd != 5'd0);
    assign mem_push = mem_valid && mem_ready && (mem_rd != 5'd0);
    assign pop      = clk_cpu && (count_q != '0);
    assign mem_slot = wr_ptr_q + AW'(alu_push);

    assign count_d  = count_q + CW'(alu_push) + CW'(mem_push) - CW'(pop);
    assign wr_ptr_d = wr_ptr_q + AW'(alu_push) + AW'(mem_push);
    assign rd_ptr_d = rd_ptr_q + AW'(pop);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ldr_q    <= 1'b0;
            rdo_q    <= '0;
            datar_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (alu_push) begin
                rd_q[wr_ptr_q]   <= alu_rd;
                data_q[wr_ptr_q] <= alu_data;
            end
            if (mem_push) begin
                rd_q[mem_slot]   <= mem_rd;
                data_q[mem_slot] <= mem_data;
            end
            if (pop) begin
                ldr_q   <= 1'b1;
                rdo_q   <= rd_q[rd_ptr_q];
                datar_q <= data_q[rd_ptr_q];
            end else if (clk_cpu) begin
                ldr_q <= 1'b0;
            end
        end
    end

    always_comb begin
        logic [AW-1:0] idx;
        idx       = '0;
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + AW'(i);
            if (CW'(i) < count_q) pend_mask[rd_q[idx]] = 1'b1;
        end
        if (ldr_q) pend_mask[rdo_q] = 1'b1;
        pend_mask[0] = 1'b0;
    end

    assign LdR   = ldr_q;
    assign RD    = rdo_q;
    assign DataR = datar_q;
    assign count = count_q;

endmodule

// File: tb/tb_reg_wb_queue.sv
// Bench for reg_wb_queue: table of vectors with hand-derived expectations,
// plus a behavioural FIFO model acting as scoreboard for every cycle.
module tb_reg_wb_queue;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        clk_cpu;
    logic        alu_valid, mem_valid;
    logic        alu_ready, mem_ready;
    logic [4:0]  alu_rd, mem_rd;
    logic [31:0] alu_data, mem_data;
    logic        LdR;
    logic [4:0]  RD;
    logic [31:0] DataR;
    logic [31:0] pend_mask;
    logic [2:0]  count;

    reg_wb_queue #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .clk_cpu(clk_cpu),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_rd(mem_rd), .mem_data(mem_data),
        .LdR(LdR), .RD(RD), .DataR(DataR),
        .pend_mask(pend_mask), .count(count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        cpu;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdat;
        logic        ear;
        logic        emr;
        int          ecnt;
        logic        eldr;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        sb[$];
    logic        m_ldr;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    int          n_pass = 0;
    int          n_total = 0;
    vec_t        tbl[23];

    function automatic vec_t mk(logic cpu, logic av, logic [4:0] ard,
                                logic [31:0] adat, logic mv, logic [4:0] mrd,
                                logic [31:0] mdat, logic ear, logic emr,
                                int ecnt, logic eldr);
        vec_t v;
        v.cpu = cpu; v.av = av; v.ard = ard; v.adat = adat;
        v.mv = mv; v.mrd = mrd; v.mdat = mdat;
        v.ear = ear; v.emr = emr; v.ecnt = ecnt; v.eldr = eldr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m;
        m = '0;
        foreach (sb[i]) m[sb[i].rd] = 1'b1;
        if (m_ldr) m[m_rd] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    // Called just after a posedge; returns just after the next posedge.
    task automatic step(input vec_t v, input bit use_exp);
        logic ear, emr;
        ent_t e;
        clk_cpu   = v.cpu;
        alu_valid = v.av; alu_rd = v.ard; alu_data = v.adat;
        mem_valid = v.mv; mem_rd = v.mrd; mem_data = v.mdat;
        #2;
        ear = sb.size() < DEPTH;
        emr = (sb.size() + int'(v.av && ear)) < DEPTH;
        chk("alu_ready", 32'(alu_ready), 32'(ear));
        chk("mem_ready", 32'(mem_ready), 32'(emr));
        chk("count_pre", 32'(count), 32'(sb.size()));
        chk("pend_mask", pend_mask, model_mask());
        if (use_exp) begin
            chk("tbl_alu_ready", 32'(alu_ready), 32'(v.ear));
            chk("tbl_mem_ready", 32'(mem_ready), 32'(v.emr));
        end
        @(posedge CLK);
        if (v.cpu) begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                m_ldr = 1'b1; m_rd = e.rd; m_data = e.data;
            end else begin
                m_ldr = 1'b0;
            end
        end
        if (v.av && ear && v.ard != 0) begin
            e.rd = v.ard; e.data = v.adat; sb.push_back(e);
        end
        if (v.mv && emr && v.mrd != 0) begin
            e.rd = v.mrd; e.data = v.mdat; sb.push_back(e);
        end
        #1;
        chk("LdR", 32'(LdR), 32'(m_ldr));
        chk("RD", 32'(RD), 32'(m_rd));
        chk("DataR", DataR, m_data);
        chk("count_post", 32'(count), 32'(sb.size()));
        if (use_exp) begin
            chk("tbl_count", 32'(count), 32'(v.ecnt));
            chk("tbl_LdR", 32'(LdR), 32'(v.eldr));
        end
        alu_valid = 1'b0;
        mem_valid = 1'b0;
    endtask

    initial begin
        logic [4:0]  hold_rd;
        logic [31:0] hold_data;

        tbl[0]  = mk(1,1,5,32'hDEADBEEF,0,0,0,    1,1,1,0);
        tbl[1]  = mk(1,0,0,0,0,0,0,               1,1,0,1);
        tbl[2]  = mk(1,0,0,0,0,0,0,               1,1,0,0);
        tbl[3]  = mk(0,1,3,32'h11,1,7,32'h22,     1,1,2,0);
        tbl[4]  = mk(1,0,0,0,0,0,0,               1,1,1,1);
        tbl[5]  = mk(1,0,0,0,0,0,0,               1,1,0,1);
        tbl[6]  = mk(1,0,0,0,0,0,0,               1,1,0,0);
        tbl[7]  = mk(0,1,1,32'hA1,1,2,32'hA2,     1,1,2,0);
        tbl[8]  = mk(0,1,4,32'hA4,0,0,0,          1,1,3,0);
        tbl[9]  = mk(0,1,8,32'hA8,1,9,32'hA9,     1,0,4,0);
        tbl[10] = mk(0,0,0,0,1,9,32'hA9,          0,0,4,0);
        tbl[11] = mk(1,0,0,0,1,9,32'hA9,          0,0,3,1);
        tbl[12] = mk(0,0,0,0,1,9,32'hA9,          1,1,4,1);
        tbl[13] = mk(1,0,0,0,0,0,0,               0,0,3,1);
        tbl[14] = mk(1,0,0,0,0,0,0,               1,1,2,1);
        tbl[15] = mk(1,0,0,0,0,0,0,               1,1,1,1);
        tbl[16] = mk(1,0,0,0,0,0,0,               1,1,0,1);
        tbl[17] = mk(1,0,0,0,0,0,0,               1,1,0,0);
        tbl[18] = mk(1,1,0,32'h55,0,0,0,          1,1,0,0);
        tbl[19] = mk(1,0,0,0,0,0,0,               1,1,0,0);
        tbl[20] = mk(1,1,0,32'h66,1,12,32'hC,     1,1,1,0);
        tbl[21] = mk(1,0,0,0,0,0,0,               1,1,0,1);
        tbl[22] = mk(1,0,0,0,0,0,0,               1,1,0,0);

        RST = 1'b1; clk_cpu = 1'b0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0;
        m_ldr = 0; m_rd = 0; m_data = 0;
        #3;
        chk("rst_LdR", 32'(LdR), 32'd0);
        chk("rst_RD", 32'(RD), 32'd0);
        chk("rst_DataR", DataR, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_pend", pend_mask, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 23; i++) step(tbl[i], 1'b1);
        chk("x0_never_written", 32'(RD), 32'd12);

        // Stall: enable pattern 1,0,0,1 must pop exactly twice.
        step(mk(0,1,13,32'hD13,1,14,32'hE14,0,0,0,0), 1'b0);
        step(mk(0,1,15,32'hF15,0,0,0,0,0,0,0), 1'b0);
        chk("stall_count3", 32'(count), 32'd3);
        step(mk(1,0,0,0,0,0,0,0,0,0,0), 1'b0);
        hold_rd = RD; hold_data = DataR;
        chk("stall_rd13", 32'(RD), 32'd13);
        step(mk(0,0,0,0,0,0,0,0,0,0,0), 1'b0);
        step(mk(0,0,0,0,0,0,0,0,0,0,0), 1'b0);
        chk("stall_hold_rd", 32'(RD), 32'(hold_rd));
        chk("stall_hold_data", DataR, hold_data);
        chk("stall_hold_ldr", 32'(LdR), 32'd1);
        step(mk(1,0,0,0,0,0,0,0,0,0,0), 1'b0);
        chk("stall_two_pops", 32'(count), 32'd1);
        chk("stall_rd14", 32'(RD), 32'd14);

        // Mid-cycle reset with three entries queued and LdR high.
        step(mk(0,1,16,32'h16,1,17,32'h17,0,0,0,0), 1'b0);
        #2;
        chk("pre_rst_count", 32'(count), 32'd3);
        chk("pre_rst_pend", pend_mask, 32'h0003_C000);
        RST = 1'b1;
        #1;
        chk("midrst_LdR", 32'(LdR), 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_pend", pend_mask, 32'd0);
        chk("midrst_RD", 32'(RD), 32'd0);
        sb.delete();
        m_ldr = 0; m_rd = 0; m_data = 0;
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        chk("post_rst_alu_ready", 32'(alu_ready), 32'd1);
        chk("post_rst_mem_ready", 32'(mem_ready), 32'd1);
        step(mk(1,1,20,32'hCAFE,0,0,0,0,0,0,0), 1'b0);
        step(mk(1,0,0,0,0,0,0,0,0,0,0), 1'b0);
        step(mk(1,0,0,0,0,0,0,0,0,0,0), 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
